shift_stream_ctrl: RTL

- Sequences one stochastic bitstream job through an internal two-tap delay line.
- Accepts a bit source via valid/ready. Latches runtime tap positions and stream length on start.
- Suppresses output during pipeline fill, then emits exactly LEN valid output pairs (out1, out2) and pulses done.
- Sits between the random/stochastic bit generators and the neuron arithmetic. It replaces free-running shifters that have no framing.

---
 rtl/etch_pkg.sv | 25 ++
 rtl/tap_delay_line.sv | 47 ++++
 rtl/shift_stream_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/etch_pkg.sv
// Shared types and defaults for the stochastic bitstream sequencing controller.
package etch_pkg;

   localparam int DEF_DEPTH = 8;
   localparam int DEF_TAP_W = 3;
   localparam int DEF_LEN_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2,
      LAST = 2'd3
   } state_t;

   // Ceiling log2, never less than 1 so it can size a counter directly.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/tap_delay_line.sv
// Delay line for one bitstream with two runtime-selectable taps.
// Tap 0 is the incoming bit itself; tap k is the bit accepted k beats earlier.
module tap_delay_line
   import etch_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int TAP_W = DEF_TAP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             clear,
   input  logic             in_data,
   input  logic [TAP_W-1:0] tap1,
   input  logic [TAP_W-1:0] tap2,
   output logic             tap1_val,
   output logic             tap2_val
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (clear) begin
         sr <= '0;
      end else if (shift_en) begin
         sr <= {sr[DEPTH-2:0], in_data};
      end
   end

   // Values as seen before this cycle's shift, so they can be registered on the same beat.
   always_comb begin
      tap1_val = in_data;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(tap1) == i + 1) tap1_val = sr[i];
      end
   end

   always_comb begin
      tap2_val = in_data;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(tap2) == i + 1) tap2_val = sr[i];
      end
   end

endmodule

// File: rtl/shift_stream_ctrl.sv
// Frames one stochastic bitstream job: pipeline fill, exactly len output pairs, done pulse.
//  state | meaning
//  IDLE  | waiting for start; illegal config gives a cfg_err pulse
//  FILL  | accepting max(tap1,tap2) beats to prime the delay line, no output
//  RUN   | each beat produces one registered (out1,out2) pair
//  LAST  | final pair and done visible, source stalled
module shift_stream_ctrl
   import etch_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int TAP_W = DEF_TAP_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [TAP_W-1:0] cfg_tap1,
   input  logic [TAP_W-1:0] cfg_tap2,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out1,
   output logic             out2,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   localparam int FILL_W = clog2(DEPTH);

   state_t state, next_state;

   logic [TAP_W-1:0]  tap1_q;
   logic [TAP_W-1:0]  tap2_q;
   logic [TAP_W-1:0]  f_cfg;
   logic [FILL_W-1:0] fill_cnt;
   logic [LEN_W-1:0]  len_cnt;
   logic              cfg_legal;
   logic              beat;
   logic              job_load;
   logic              job_abort;
   logic              cfg_reject;
   logic              sr_clear;
   logic              tap1_val;
   logic              tap2_val;

   assign f_cfg     = (cfg_tap1 > cfg_tap2) ? cfg_tap1 : cfg_tap2;
   assign cfg_legal = (cfg_len != '0) && (int'(cfg_tap1) < DEPTH) && (int'(cfg_tap2) < DEPTH);
   assign in_ready  = (state == FILL) || (state == RUN);
   assign busy      = (state != IDLE);
   assign beat      = in_valid && in_ready;
   assign job_abort = abort && busy;
   assign sr_clear  = job_load || job_abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      job_load   = 1'b0;
      cfg_reject = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_legal) begin
                  job_load   = 1'b1;
                  next_state = (f_cfg != '0) ? FILL : RUN;
               end else begin
                  cfg_reject = 1'b1;
               end
            end
         end
         FILL: begin
            if (beat && (fill_cnt == FILL_W'(1))) next_state = RUN;
         end
         RUN: begin
            if (beat && (len_cnt == LEN_W'(1))) next_state = LAST;
         end
         LAST: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (job_abort) next_state = IDLE;
   end

   // Output pair registers default to zero so out1/out2 can never show stale data.
   always_ff @(posedge clk) begin
      if (rst) begin
         tap1_q    <= '0;
         tap2_q    <= '0;
         fill_cnt  <= '0;
         len_cnt   <= '0;
         out1      <= 1'b0;
         out2      <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err   <= cfg_reject;
         out1      <= 1'b0;
         out2      <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         if (job_load) begin
            tap1_q   <= cfg_tap1;
            tap2_q   <= cfg_tap2;
            fill_cnt <= FILL_W'(f_cfg);
            len_cnt  <= cfg_len;
         end else if (job_abort) begin
            fill_cnt <= '0;
            len_cnt  <= '0;
         end else if (beat && (state == FILL)) begin
            fill_cnt <= fill_cnt - FILL_W'(1);
         end else if (beat && (state == RUN)) begin
            len_cnt   <= len_cnt - LEN_W'(1);
            out1      <= tap1_val;
            out2      <= tap2_val;
            out_valid <= 1'b1;
            done      <= (len_cnt == LEN_W'(1));
         end
      end
   end

   tap_delay_line #(
      .DEPTH (DEPTH),
      .TAP_W (TAP_W)
   ) u_delay (
      .clk      (clk),
      .rst      (rst),
      .shift_en (beat),
      .clear    (sr_clear),
      .in_data  (in_data),
      .tap1     (tap1_q),
      .tap2     (tap2_q),
      .tap1_val (tap1_val),
      .tap2_val (tap2_val)
   );

endmodule
